vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port synchronous video/system RAM between three requesters:
//  DVI scanout (video), the micro86 CPU bus and the SD-card loader DMA.
//  Sits between micro86 core, video generator and sd_card loader; owns all RAM
//  control pins. Video has fixed priority; CPU and DMA alternate round-robin.
// PARAMETERS
//  ADDR_WIDTH  15  RAM word address width
//  DATA_WIDTH   8  RAM word width
// PORTS
//  clk          in   1     system clock; single clock domain
//  reset        in   1     synchronous, active-low reset
//  video_req    in   1     video read request (may assert every cycle)
//  video_addr   in   AW    video read address
//  video_rdata  out  DW    video read data
//  video_rvalid out  1     video_rdata valid pulse
//  cpu_req      in   1     CPU access request; held until cpu_ready
//  cpu_we       in   1     1 = write, 0 = read
//  cpu_addr     in   AW    CPU address
//  cpu_wdata    in   DW    CPU write data
//  cpu_rdata    out  DW    CPU read data
//  cpu_ready    out  1     one-cycle completion pulse (reads and writes)
//  dma_req/dma_we/dma_addr/dma_wdata/dma_rdata/dma_ready: same as cpu_*
//  mem_en       out  1     RAM enable
//  mem_we       out  1     RAM write enable
//  mem_addr     out  AW    RAM address
//  mem_wdata    out  DW    RAM write data
//  mem_rdata    in   DW    RAM read data, valid 1 cycle after mem_en
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all outputs 0, in-flight pipeline flags,
//    CPU/DMA busy flags cleared, RR pointer = CPU. No ready/rvalid pulse is
//    ever produced for a transaction issued before reset.
//  - Pipeline: stage0 cycle N: requests sampled, winner chosen, mem_* registered;
//    cycle N+1: RAM access; cycle N+2: mem_rdata routed to winner, its
//    rvalid/ready pulses for exactly one cycle. Uncontested latency = 2 cycles.
//  - Arbitration per cycle: video_req wins if set. Else eligible CPU/DMA
//    (req && !busy) chosen; if both, the one not granted last wins; RR pointer
//    updates only on CPU/DMA grant. No request -> mem_en=0, mem_we=0.
//  - Video is fully pipelined: one read per cycle, rvalid stream matches request
//    order; video never issues writes (mem_we=0 on video grant).
//  - CPU/DMA: one outstanding each. busy set on grant, cleared in ready cycle.
//    req is ignored while busy and in the ready cycle itself; req high in the
//    cycle after ready is a new transaction.
//  - Writes: mem_we=1 with grant; ready pulses at N+2 like reads; rdata for writes
//    is don't-care but held stable (rdata regs update only on own read completion).
//  - *_rdata hold last value until next own read completes.
//  - Starvation: CPU/DMA may wait indefinitely while video_req is continuously
//    high (active scanline); video generator guarantees idle during blanking.
//  - CPU and DMA writing the same address: serialised by grant order; later wins.
// STRUCTURE
//  - Shared include (memory_bus.vinc): requester ID constants REQ_NONE=0,
//    REQ_VIDEO=1, REQ_CPU=2, REQ_DMA=3; 2-bit owner tag carried down pipeline.
//  - Single module, no sub-modules: grant logic, 2-stage owner/valid tag pipe,
//    busy flags, RR pointer, return demux.
// TESTING
//  - Single CPU read addr 0x0123 (RAM=0x5A), no contention -> cpu_ready and
//    cpu_rdata=0x5A exactly 2 cycles after first req cycle; mem_we=0.
//  - video_req high 8 cycles, addr 0..7 -> 8 consecutive rvalid pulses, data
//    RAM[0..7] in order, starting 2 cycles after first req; cpu_req held
//    meanwhile gets grant in first cycle video_req drops.
//  - CPU and DMA req same cycle (video idle), req held continuously -> grants
//    alternate CPU, DMA, CPU, DMA; neither granted twice in a row while other waits.
//  - DMA write 0xA5 to 0x7FFF then CPU read 0x7FFF -> cpu_rdata=0xA5; dma_ready
//    2 cycles after write grant; mem_we high for exactly one cycle.
//  - Assert reset=0 one cycle after CPU grant -> no cpu_ready pulse; all outputs
//    0; after release, new cpu_req completes normally in 2 cycles.
//  - cpu_req held high through ready cycle then dropped -> exactly one RAM access
//    (mem_en count = 1) for that transaction.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter.
//   owner_t  : requester ID carried down the access pipeline
//              (REQ_NONE=0, REQ_VIDEO=1, REQ_CPU=2, REQ_DMA=3)
//   tag_t    : per-stage pipeline tag (owner + write flag)
//   PIPE_DEPTH : cycles from grant register to data return
//   rr_other : the CPU/DMA requester that was not just granted
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_VIDEO = 2'd1,
        REQ_CPU   = 2'd2,
        REQ_DMA   = 2'd3
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   we;
    } tag_t;

    // Stage 1 travels with the RAM access, stage 2 lines up with mem_rdata.
    localparam int PIPE_DEPTH = 2;

    function automatic owner_t rr_other(input owner_t granted);
        return (granted == REQ_CPU) ? REQ_DMA : REQ_CPU;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port RAM arbiter for video scanout, CPU bus and SD-card DMA.
//   clk, reset (sync, active low)
//   video_req/video_addr -> video_rdata/video_rvalid : pipelined reads, top priority
//   cpu_*  / dma_*       : one outstanding access each, round-robin between them,
//                          *_ready pulses once per access (reads and writes)
//   mem_en/mem_we/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM (1-cycle latency)
// A grant decided in cycle N is registered onto mem_* for cycle N+1 and its
// data/pulse is returned in cycle N+2.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  video_req,
    input  logic [ADDR_WIDTH-1:0] video_addr,
    output logic [DATA_WIDTH-1:0] video_rdata,
    output logic                  video_rvalid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Client index 0 = CPU, 1 = DMA; both share identical handshake logic.
    logic [1:0]            client_req;
    logic [1:0]            client_we;
    logic [1:0]            client_busy;
    logic [1:0]            client_ready;
    logic [1:0]            client_elig;
    logic [ADDR_WIDTH-1:0] client_addr  [2];
    logic [DATA_WIDTH-1:0] client_wdata [2];
    logic [DATA_WIDTH-1:0] client_rdata [2];

    owner_t                grant_owner;
    logic                  grant_we;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_wdata;

    owner_t                rr_reg;
    owner_t                rr_next;
    tag_t                  pipe_reg [PIPE_DEPTH];
    tag_t                  ret_tag;
    logic [DATA_WIDTH-1:0] video_rdata_reg;

    assign client_req      = {dma_req, cpu_req};
    assign client_we       = {dma_we, cpu_we};
    assign client_addr[0]  = cpu_addr;
    assign client_addr[1]  = dma_addr;
    assign client_wdata[0] = cpu_wdata;
    assign client_wdata[1] = dma_wdata;

    // Busy covers grant through the ready cycle, so a request still held
    // during ready is not mistaken for a new transaction.
    assign client_elig = client_req & ~client_busy;

    // ------------------------------------------------------------------
    // Arbitration: video first, then CPU/DMA with rr_reg naming the
    // requester that wins a tie.
    // ------------------------------------------------------------------
    always_comb begin
        grant_owner = REQ_NONE;
        grant_we    = 1'b0;
        grant_addr  = '0;
        grant_wdata = '0;
        rr_next     = rr_reg;
        if (video_req) begin
            grant_owner = REQ_VIDEO;
            grant_addr  = video_addr;
        end else if (client_elig[0] && (!client_elig[1] || rr_reg == REQ_CPU)) begin
            grant_owner = REQ_CPU;
            grant_we    = cpu_we;
            grant_addr  = cpu_addr;
            grant_wdata = cpu_wdata;
            rr_next     = rr_other(REQ_CPU);
        end else if (client_elig[1]) begin
            grant_owner = REQ_DMA;
            grant_we    = dma_we;
            grant_addr  = dma_addr;
            grant_wdata = dma_wdata;
            rr_next     = rr_other(REQ_DMA);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_reg    <= REQ_CPU;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_reg[i] <= '{owner: REQ_NONE, we: 1'b0};
            end
        end else begin
            rr_reg      <= rr_next;
            mem_en      <= (grant_owner != REQ_NONE);
            mem_we      <= grant_we;
            mem_addr    <= grant_addr;
            mem_wdata   <= grant_wdata;
            pipe_reg[0] <= '{owner: grant_owner, we: grant_we};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    // Tag aligned with mem_rdata: selects who receives this cycle's return.
    assign ret_tag = pipe_reg[PIPE_DEPTH-1];

    // ------------------------------------------------------------------
    // Video return: pass mem_rdata straight through on the valid cycle,
    // otherwise show the last word read.
    // ------------------------------------------------------------------
    assign video_rvalid = (ret_tag.owner == REQ_VIDEO);
    assign video_rdata  = video_rvalid ? mem_rdata : video_rdata_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            video_rdata_reg <= '0;
        end else if (video_rvalid) begin
            video_rdata_reg <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // CPU / DMA handshake: busy flag, completion pulse, held read data.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : gen_client
        localparam owner_t CLIENT_OWNER = (gi == 0) ? REQ_CPU : REQ_DMA;

        logic                  busy_reg;
        logic [DATA_WIDTH-1:0] rdata_reg;
        logic                  done;
        logic                  done_read;

        assign done      = (ret_tag.owner == CLIENT_OWNER);
        assign done_read = done && !ret_tag.we;

        // Grant requires !busy and done implies busy, so they never coincide.
        always_ff @(posedge clk) begin
            if (!reset) begin
                busy_reg  <= 1'b0;
                rdata_reg <= '0;
            end else begin
                if (grant_owner == CLIENT_OWNER) begin
                    busy_reg <= 1'b1;
                end else if (done) begin
                    busy_reg <= 1'b0;
                end
                if (done_read) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end

        assign client_busy[gi]  = busy_reg;
        assign client_ready[gi] = done;
        assign client_rdata[gi] = done_read ? mem_rdata : rdata_reg;
    end

    assign cpu_ready = client_ready[0];
    assign cpu_rdata = client_rdata[0];
    assign dma_ready = client_ready[1];
    assign dma_rdata = client_rdata[1];

endmodule
